// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: NUM_MASTERS masters share one slave port.
// A grant is held for the whole bus cycle, and a stalled cycle is ended with a one-cycle error.
module wb_rr_arbiter #(
  parameter int NUM_MASTERS = 2,
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  // flattened master request ports, master 0 in the LSBs
  input  logic [NUM_MASTERS*AW-1:0]     wbm_adr_i,
  input  logic [NUM_MASTERS*DW-1:0]     wbm_dat_i,
  input  logic [NUM_MASTERS*(DW/8)-1:0] wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]        wbm_we_i,
  input  logic [NUM_MASTERS-1:0]        wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]        wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]      wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]      wbm_bte_i,
  // flattened master response ports
  output logic [NUM_MASTERS*DW-1:0]     wbm_dat_o,
  output logic [NUM_MASTERS-1:0]        wbm_ack_o,
  output logic [NUM_MASTERS-1:0]        wbm_err_o,
  output logic [NUM_MASTERS-1:0]        wbm_rty_o,
  // shared slave port
  output logic [AW-1:0]                 wbs_adr_o,
  output logic [DW-1:0]                 wbs_dat_o,
  output logic [DW/8-1:0]               wbs_sel_o,
  output logic                          wbs_we_o,
  output logic                          wbs_cyc_o,
  output logic                          wbs_stb_o,
  output logic [2:0]                    wbs_cti_o,
  output logic [1:0]                    wbs_bte_o,
  input  logic [DW-1:0]                 wbs_dat_i,
  input  logic                          wbs_ack_i,
  input  logic                          wbs_err_i,
  input  logic                          wbs_rty_i,
  output logic [NUM_MASTERS-1:0]        grant_o
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam int SW = DW / 8;
  // The error fires in the cycle the stall count would reach TIMEOUT.
  localparam logic [15:0]            STALL_LIMIT = 16'(TIMEOUT - 1);
  localparam logic [IW-1:0]          LAST_INIT   = IW'(NUM_MASTERS - 1);
  localparam logic [NUM_MASTERS-1:0] ONE_HOT0    = NUM_MASTERS'(1);

  typedef enum logic {
    S_IDLE,
    S_OWN
  } state_t;

  state_t        state;
  logic [IW-1:0] owner_idx;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] rr_winner;
  logic [IW-1:0] sel_idx;
  logic [15:0]   stall_cnt;
  logic          own;
  logic          any_req;
  logic          err_pulse;
  logic          slave_resp;
  logic [NUM_MASTERS-1:0] resp_en;

  logic [AW-1:0] adr_arr [NUM_MASTERS];
  logic [DW-1:0] dat_arr [NUM_MASTERS];
  logic [SW-1:0] sel_arr [NUM_MASTERS];
  logic [2:0]    cti_arr [NUM_MASTERS];
  logic [1:0]    bte_arr [NUM_MASTERS];

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
    assign adr_arr[g] = wbm_adr_i[g*AW +: AW];
    assign dat_arr[g] = wbm_dat_i[g*DW +: DW];
    assign sel_arr[g] = wbm_sel_i[g*SW +: SW];
    assign cti_arr[g] = wbm_cti_i[g*3 +: 3];
    assign bte_arr[g] = wbm_bte_i[g*2 +: 2];
  end

  // First requester found scanning upward from the master after last_grant, wrapping.
  function automatic logic [IW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req,
                                            input logic [IW-1:0]          last);
    logic [IW-1:0] pick;
    logic [IW-1:0] idx;
    logic          found;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      idx = IW'((int'(last) + k) % NUM_MASTERS);
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign own        = (state == S_OWN);
  assign any_req    = |wbm_cyc_i;
  assign rr_winner  = rr_pick(wbm_cyc_i, last_grant);
  assign slave_resp = wbs_ack_i | wbs_err_i | wbs_rty_i;

  assign err_pulse = own && wbm_cyc_i[owner_idx] && wbm_stb_i[owner_idx]
                     && (stall_cnt == STALL_LIMIT);

  // NOTE: a selector written in always_comb gets a default first so no path leaves it unassigned (latch).
  always_comb begin
    sel_idx = '0;
    if (own) sel_idx = owner_idx;
  end

  // Idle keeps master 0's fields on the slave port so the don't-care outputs stay stable.
  assign wbs_adr_o = adr_arr[sel_idx];
  assign wbs_dat_o = dat_arr[sel_idx];
  assign wbs_sel_o = sel_arr[sel_idx];
  assign wbs_we_o  = wbm_we_i[sel_idx];
  assign wbs_cti_o = cti_arr[sel_idx];
  assign wbs_bte_o = bte_arr[sel_idx];
  assign wbs_cyc_o = own && wbm_cyc_i[owner_idx] && !err_pulse && !wb_rst_i;
  assign wbs_stb_o = own && wbm_stb_i[owner_idx] && !err_pulse && !wb_rst_i;

  // grant_o is only non-zero while owning, so an ack with no owner reaches nobody.
  assign resp_en   = wb_rst_i ? '0 : grant_o;
  assign wbm_dat_o = {NUM_MASTERS{wbs_dat_i}};
  assign wbm_ack_o = resp_en & {NUM_MASTERS{wbs_ack_i & ~err_pulse}};
  assign wbm_err_o = resp_en & {NUM_MASTERS{wbs_err_i | err_pulse}};
  assign wbm_rty_o = resp_en & {NUM_MASTERS{wbs_rty_i & ~err_pulse}};

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state      <= S_IDLE;
      grant_o    <= '0;
      owner_idx  <= '0;
      last_grant <= LAST_INIT;
      stall_cnt  <= '0;
    end else begin
      if (own && wbs_stb_o && !slave_resp) stall_cnt <= stall_cnt + 16'd1;
      else                                  stall_cnt <= '0;

      case (state)
        S_IDLE: begin
          if (any_req) begin
            state     <= S_OWN;
            owner_idx <= rr_winner;
            grant_o   <= ONE_HOT0 << rr_winner;
          end
        end
        S_OWN: begin
          if (!wbm_cyc_i[owner_idx]) begin
            state      <= S_IDLE;
            last_grant <= owner_idx;
            grant_o    <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Self-checking bench for wb_rr_arbiter: directed vector table, corner-case sequences,
// then randomized traffic checked against a behavioural ownership model.
module tb_wb_rr_arbiter;

  localparam int N       = 3;
  localparam int AW      = 16;
  localparam int DW      = 32;
  localparam int SW      = DW / 8;
  localparam int TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst;

  logic [AW-1:0] m_adr [N];
  logic [DW-1:0] m_dat [N];
  logic [SW-1:0] m_sel [N];
  logic [2:0]    m_cti [N];
  logic [1:0]    m_bte [N];
  logic [N-1:0]  m_we, m_cyc, m_stb;
  logic [DW-1:0] s_dat;
  logic          s_ack, s_err, s_rty;

  logic [N*AW-1:0] wbm_adr_i;
  logic [N*DW-1:0] wbm_dat_i;
  logic [N*SW-1:0] wbm_sel_i;
  logic [N*3-1:0]  wbm_cti_i;
  logic [N*2-1:0]  wbm_bte_i;
  logic [N*DW-1:0] wbm_dat_o;
  logic [N-1:0]    wbm_ack_o, wbm_err_o, wbm_rty_o, grant_o;
  logic [AW-1:0]   wbs_adr_o;
  logic [DW-1:0]   wbs_dat_o;
  logic [SW-1:0]   wbs_sel_o;
  logic            wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]      wbs_cti_o;
  logic [1:0]      wbs_bte_o;

  always_comb begin
    wbm_adr_i = '0;
    wbm_dat_i = '0;
    wbm_sel_i = '0;
    wbm_cti_i = '0;
    wbm_bte_i = '0;
    for (int i = 0; i < N; i++) begin
      wbm_adr_i[i*AW +: AW] = m_adr[i];
      wbm_dat_i[i*DW +: DW] = m_dat[i];
      wbm_sel_i[i*SW +: SW] = m_sel[i];
      wbm_cti_i[i*3 +: 3]   = m_cti[i];
      wbm_bte_i[i*2 +: 2]   = m_bte[i];
    end
  end

  wb_rr_arbiter #(.NUM_MASTERS(N), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i  (clk),
    .wb_rst_i  (rst),
    .wbm_adr_i (wbm_adr_i),
    .wbm_dat_i (wbm_dat_i),
    .wbm_sel_i (wbm_sel_i),
    .wbm_we_i  (m_we),
    .wbm_cyc_i (m_cyc),
    .wbm_stb_i (m_stb),
    .wbm_cti_i (wbm_cti_i),
    .wbm_bte_i (wbm_bte_i),
    .wbm_dat_o (wbm_dat_o),
    .wbm_ack_o (wbm_ack_o),
    .wbm_err_o (wbm_err_o),
    .wbm_rty_o (wbm_rty_o),
    .wbs_adr_o (wbs_adr_o),
    .wbs_dat_o (wbs_dat_o),
    .wbs_sel_o (wbs_sel_o),
    .wbs_we_o  (wbs_we_o),
    .wbs_cyc_o (wbs_cyc_o),
    .wbs_stb_o (wbs_stb_o),
    .wbs_cti_o (wbs_cti_o),
    .wbs_bte_o (wbs_bte_o),
    .wbs_dat_i (s_dat),
    .wbs_ack_i (s_ack),
    .wbs_err_i (s_err),
    .wbs_rty_i (s_rty),
    .grant_o   (grant_o)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: owner is -1 when nobody holds the bus; stalls counts
  // consecutive cycles the owner's strobe went unanswered.
  int owner = -1, last = N - 1, stalls = 0;
  int nxt_owner, nxt_last, nxt_stalls;

  task automatic model_check();
    int          sel;
    bit          stb_req, errp, en, exp_cyc, exp_stb;
    logic [N-1:0] g, ack, err, rty;
    sel     = (owner >= 0) ? owner : 0;
    stb_req = (owner >= 0) && m_cyc[sel] && m_stb[sel];
    errp    = stb_req && (stalls + 1 == TIMEOUT);
    en      = !rst && (owner >= 0);
    g       = (owner >= 0) ? (N'(1) << owner) : '0;
    ack = '0; err = '0; rty = '0;
    if (en) begin
      ack[sel] = s_ack && !errp;
      err[sel] = s_err || errp;
      rty[sel] = s_rty && !errp;
    end
    exp_cyc = en && m_cyc[sel] && !errp;
    exp_stb = en && m_stb[sel] && !errp;
    check("grant", 128'(grant_o), 128'(g));
    check("wbs_cyc_stb", 128'({wbs_cyc_o, wbs_stb_o}), 128'({exp_cyc, exp_stb}));
    check("wbs_req", 128'({wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cti_o, wbs_bte_o}),
          128'({m_adr[sel], m_dat[sel], m_sel[sel], m_we[sel], m_cti[sel], m_bte[sel]}));
    check("wbm_resp", 128'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 128'({ack, err, rty}));
    check("wbm_dat", 128'(wbm_dat_o), 128'({N{s_dat}}));

    nxt_owner  = owner;
    nxt_last   = last;
    nxt_stalls = (exp_stb && !(s_ack || s_err || s_rty)) ? stalls + 1 : 0;
    if (rst) begin
      nxt_owner  = -1;
      nxt_last   = N - 1;
      nxt_stalls = 0;
    end else if (owner < 0) begin
      for (int k = 1; k <= N; k++) begin
        if (nxt_owner < 0 && m_cyc[(last + k) % N]) nxt_owner = (last + k) % N;
      end
    end else if (!m_cyc[owner]) begin
      nxt_last  = owner;
      nxt_owner = -1;
    end
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic commit();
    @(posedge clk);
    owner  = nxt_owner;
    last   = nxt_last;
    stalls = nxt_stalls;
    #1;
  endtask

  task automatic step();
    settle();
    model_check();
    commit();
  endtask

  typedef struct {
    logic       rst;
    logic [2:0] cyc;
    logic       s_ack;
    logic [2:0] exp_grant;
    logic       exp_cyc;
    logic [2:0] exp_ack;
  } vec_t;

  vec_t tbl [13];

  initial begin
    tbl[0]  = '{1'b1, 3'b000, 1'b0, 3'b000, 1'b0, 3'b000};
    tbl[1]  = '{1'b0, 3'b011, 1'b0, 3'b000, 1'b0, 3'b000};
    tbl[2]  = '{1'b0, 3'b011, 1'b1, 3'b001, 1'b1, 3'b001};
    tbl[3]  = '{1'b0, 3'b010, 1'b0, 3'b001, 1'b0, 3'b000};
    tbl[4]  = '{1'b0, 3'b010, 1'b0, 3'b000, 1'b0, 3'b000};
    tbl[5]  = '{1'b0, 3'b010, 1'b1, 3'b010, 1'b1, 3'b010};
    tbl[6]  = '{1'b0, 3'b000, 1'b0, 3'b010, 1'b0, 3'b000};
    tbl[7]  = '{1'b0, 3'b100, 1'b1, 3'b000, 1'b0, 3'b000};
    tbl[8]  = '{1'b0, 3'b101, 1'b0, 3'b100, 1'b1, 3'b000};
    tbl[9]  = '{1'b0, 3'b001, 1'b0, 3'b100, 1'b0, 3'b000};
    tbl[10] = '{1'b0, 3'b001, 1'b0, 3'b000, 1'b0, 3'b000};
    tbl[11] = '{1'b0, 3'b001, 1'b1, 3'b001, 1'b1, 3'b001};
    tbl[12] = '{1'b0, 3'b000, 1'b0, 3'b001, 1'b0, 3'b000};

    for (int i = 0; i < N; i++) begin
      m_adr[i] = AW'(16'h1000 + i);
      m_dat[i] = DW'(32'hA500_0000 + i);
      m_sel[i] = SW'(i + 1);
      m_cti[i] = 3'b000;
      m_bte[i] = 2'(i);
    end
    m_we  = 3'b010;
    m_cyc = '0;
    m_stb = '0;
    s_dat = 32'hDEAD_BEEF;
    s_ack = 1'b0;
    s_err = 1'b0;
    s_rty = 1'b0;
    rst   = 1'b1;
    @(posedge clk);
    #1;

    // Directed table: reset, simultaneous request, release/idle/regrant, wrap, idle ack.
    for (int i = 0; i < 13; i++) begin
      rst   = tbl[i].rst;
      m_cyc = tbl[i].cyc;
      m_stb = tbl[i].cyc;
      s_ack = tbl[i].s_ack;
      settle();
      model_check();
      check($sformatf("tbl%0d_grant", i), 128'(grant_o), 128'(tbl[i].exp_grant));
      check($sformatf("tbl%0d_cyc", i), 128'(wbs_cyc_o), 128'(tbl[i].exp_cyc));
      check($sformatf("tbl%0d_ack", i), 128'(wbm_ack_o), 128'(tbl[i].exp_ack));
      commit();
    end

    // Master 1 burst while master 0 waits: no interleaving, master 0 never acked.
    m_cyc = 3'b011;
    m_stb = 3'b011;
    s_ack = 1'b0;
    step();
    for (int b = 0; b < 4; b++) begin
      m_cti[1] = (b == 3) ? 3'b111 : 3'b010;
      s_ack    = 1'b1;
      settle();
      model_check();
      check("burst_grant", 128'(grant_o), 128'(3'b010));
      check("burst_m0_ack", 128'(wbm_ack_o[0]), 128'(1'b0));
      check("burst_cti", 128'(wbs_cti_o), 128'(m_cti[1]));
      commit();
    end
    m_cti[1] = 3'b000;
    m_cyc    = 3'b001;
    m_stb    = 3'b001;
    s_ack    = 1'b0;
    step();
    step();
    settle();
    model_check();
    check("burst_then_m0", 128'(grant_o), 128'(3'b001));
    commit();
    m_cyc = '0;
    m_stb = '0;
    step();

    // Slave never answers: error on every TIMEOUT-th stalled cycle, strobe dropped there.
    m_cyc = 3'b001;
    m_stb = 3'b001;
    step();
    for (int k = 1; k <= 17; k++) begin
      settle();
      model_check();
      check($sformatf("to%0d_err", k), 128'(wbm_err_o[0]), 128'((k % TIMEOUT) == 0));
      check($sformatf("to%0d_stb", k), 128'(wbs_stb_o), 128'((k % TIMEOUT) != 0));
      commit();
    end
    m_cyc = '0;
    m_stb = '0;
    step();

    // Lone master 1 requesting repeatedly is regranted one cycle after each request.
    for (int r = 0; r < 3; r++) begin
      m_cyc = 3'b010;
      m_stb = 3'b010;
      s_ack = 1'b0;
      settle();
      model_check();
      check("lone_idle", 128'(grant_o), 128'(3'b000));
      commit();
      s_ack = 1'b1;
      settle();
      model_check();
      check("lone_grant", 128'({grant_o, wbs_cyc_o}), 128'({3'b010, 1'b1}));
      commit();
      m_cyc = '0;
      m_stb = '0;
      s_ack = 1'b0;
      step();
    end

    // Reset during a master 0 write restarts arbitration from master 0.
    m_we  = 3'b001;
    m_cyc = 3'b001;
    m_stb = 3'b001;
    step();
    s_ack = 1'b1;
    step();
    m_cyc = '0;
    m_stb = '0;
    s_ack = 1'b0;
    step();
    m_cyc = 3'b001;
    m_stb = 3'b001;
    step();
    settle();
    model_check();
    check("rst_pre_write", 128'({wbs_cyc_o, wbs_stb_o, wbs_we_o}), 128'(3'b111));
    commit();
    rst   = 1'b1;
    m_cyc = 3'b011;
    m_stb = 3'b011;
    s_ack = 1'b1;
    settle();
    model_check();
    check("rst_resp_zero", 128'({wbm_ack_o, wbm_err_o, wbm_rty_o}), 128'(0));
    commit();
    rst   = 1'b0;
    s_ack = 1'b0;
    settle();
    model_check();
    check("rst_after", 128'({grant_o, wbs_cyc_o, wbs_stb_o}), 128'(0));
    commit();
    settle();
    model_check();
    check("rst_first_m0", 128'(grant_o), 128'(3'b001));
    commit();
    m_cyc = '0;
    m_stb = '0;
    step();

    // Randomized traffic; phase sets how often the slave answers (phase 0 never).
    for (int p = 0; p < 4; p++) begin
      for (int c = 0; c < 100; c++) begin
        rst = ($urandom_range(63) == 0);
        for (int i = 0; i < N; i++) begin
          m_cyc[i] = ($urandom_range(15) != 0);
          m_stb[i] = m_cyc[i] && ($urandom_range(7) != 0);
          m_we[i]  = 1'($urandom_range(1));
          m_adr[i] = AW'($urandom);
          m_dat[i] = DW'($urandom);
          m_sel[i] = SW'($urandom);
          m_cti[i] = 3'($urandom);
          m_bte[i] = 2'($urandom);
        end
        s_dat = DW'($urandom);
        s_ack = ($urandom_range(7) < p);
        s_err = ($urandom_range(31) == 0);
        s_rty = ($urandom_range(31) == 0);
        step();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
